int_rx_param: RTL

Parametrised successor to the UART receive interface. Pops bytes from the UART RX FIFO and assembles a command frame: operand A, operand B, opcode, terminator. Each operand is DATA_W bits wide, received little-endian. On a valid frame it drives the operands and opcode to the ALU handler over data_out/SEL, one word at a time, then pulses DONE. Sits between the RX FIFO and the ALU_HANDLER.

---
 rtl/int_rx_param_if.sv | 33 +++
 rtl/int_rx_param.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/int_rx_param_if.sv
// Bus between int_rx_param, its RX FIFO and the ALU handler.
// master = the receiver (int_rx_param); slave = the FIFO/ALU side.
interface int_rx_param_if #(
    parameter int DATA_W = 8
);
    // Handshake: FIFO_empty=0 means data_in is valid; RD_FIFO is the ready/pop.
    // A byte transfers on the rising edge where FIFO_empty=0 and RD_FIFO=1.
    // On the ALU side each non-zero SEL cycle is one transfer of data_out.
    logic              FIFO_empty;
    logic [7:0]        data_in;
    logic              RD_FIFO;
    logic [DATA_W-1:0] data_out;
    logic [2:0]        SEL;
    logic              DONE;

    modport master (
        input  FIFO_empty,
        input  data_in,
        output RD_FIFO,
        output data_out,
        output SEL,
        output DONE
    );

    modport slave (
        output FIFO_empty,
        output data_in,
        input  RD_FIFO,
        input  data_out,
        input  SEL,
        input  DONE
    );
endinterface

// File: rtl/int_rx_param.sv
// Frame receiver: pops A, B (DATA_W each, little-endian), opcode, terminator, then loads the ALU.
// Optional inter-byte timeout is built when INT_RX_TIMEOUT_EN is defined.
module int_rx_param #(
    parameter int         DATA_W      = 8,
    parameter logic [7:0] TERM        = 8'h0D,
    parameter int         TIMEOUT_CYC = 100000
) (
    input  logic              CLK,
    input  logic              RESET,
    int_rx_param_if.master    bus,
    output logic [2:0]        STATE,
    output logic [DATA_W-1:0] DATOA,
    output logic [DATA_W-1:0] DATOB,
    output logic [7:0]        OP,
    output logic              ERR
);
    localparam int NB = DATA_W / 8;
    localparam int KW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [2:0] {
        RX_A    = 3'd0,
        RX_B    = 3'd1,
        RX_OP   = 3'd2,
        RX_TERM = 3'd3,
        LD_A    = 3'd4,
        LD_B    = 3'd5,
        LD_OP   = 3'd6,
        FIN     = 3'd7
    } state_t;

    if (DATA_W % 8 != 0 || DATA_W < 8 || DATA_W > 32 || TIMEOUT_CYC < 2) begin : g_param_check
        $error("int_rx_param: illegal DATA_W or TIMEOUT_CYC");
    end

    state_t        state, state_nx;
    logic [KW-1:0] k, k_nx;
    logic          in_rx, pop, last_byte, drop;

    assign in_rx  = (state == RX_A) || (state == RX_B) || (state == RX_OP) || (state == RX_TERM);
    assign pop    = in_rx && !bus.FIFO_empty && RESET;
    assign bus.RD_FIFO = pop;
    assign STATE  = state;
    assign last_byte = (k == KW'(NB - 1));

`ifdef INT_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC);
    logic [TW-1:0] tcnt, tcnt_inc;
    logic          in_frame, tmo_hit;

    // A frame is in progress once any byte of it has been popped.
    assign in_frame = in_rx && ((k != '0) || (state != RX_A));
    assign tcnt_inc = tcnt + TW'(1);
    assign tmo_hit  = in_frame && !pop && (tcnt_inc == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge CLK) begin
        if (!RESET)
            tcnt <= '0;
        else if (pop || tmo_hit || (state != RX_A && state_nx == RX_A))
            tcnt <= '0;
        else if (in_frame)
            tcnt <= tcnt_inc;
    end
`endif

    always_comb begin
        state_nx = state;
        k_nx     = k;
        drop     = 1'b0;
        case (state)
            RX_A: if (pop) begin
                if (last_byte) begin
                    k_nx     = '0;
                    state_nx = RX_B;
                end else begin
                    k_nx = k + 1'b1;
                end
            end
            RX_B: if (pop) begin
                if (last_byte) begin
                    k_nx     = '0;
                    state_nx = RX_OP;
                end else begin
                    k_nx = k + 1'b1;
                end
            end
            RX_OP:   if (pop) state_nx = RX_TERM;
            RX_TERM: if (pop) begin
                if (bus.data_in == TERM) begin
                    state_nx = LD_A;
                end else begin
                    drop     = 1'b1;
                    k_nx     = '0;
                    state_nx = RX_A;
                end
            end
            LD_A:    state_nx = LD_B;
            LD_B:    state_nx = LD_OP;
            LD_OP:   state_nx = FIN;
            FIN:     state_nx = RX_A;
            default: state_nx = RX_A;
        endcase
`ifdef INT_RX_TIMEOUT_EN
        if (tmo_hit) begin
            drop     = 1'b1;
            k_nx     = '0;
            state_nx = RX_A;
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state        <= RX_A;
            k            <= '0;
            DATOA        <= '0;
            DATOB        <= '0;
            OP           <= '0;
            bus.data_out <= '0;
            bus.SEL      <= '0;
            bus.DONE     <= 1'b0;
            ERR          <= 1'b0;
        end else begin
            state    <= state_nx;
            k        <= k_nx;
            ERR      <= drop;
            bus.DONE <= (state_nx == FIN);
            // Load strobes are registered off the next state so SEL and data_out move together.
            case (state_nx)
                LD_A: begin
                    bus.SEL      <= 3'b001;
                    bus.data_out <= DATOA;
                end
                LD_B: begin
                    bus.SEL      <= 3'b010;
                    bus.data_out <= DATOB;
                end
                LD_OP: begin
                    bus.SEL      <= 3'b100;
                    bus.data_out <= DATA_W'(OP);
                end
                default: begin
                    bus.SEL      <= 3'b000;
                    bus.data_out <= '0;
                end
            endcase
            if (pop) begin
                case (state)
                    RX_A:
                        for (int i = 0; i < NB; i++)
                            if (k == KW'(i)) DATOA[8*i +: 8] <= bus.data_in;
                    RX_B:
                        for (int i = 0; i < NB; i++)
                            if (k == KW'(i)) DATOB[8*i +: 8] <= bus.data_in;
                    RX_OP:   OP <= bus.data_in;
                    default: ;
                endcase
            end
        end
    end
endmodule
